// File: rtl/int_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, fixed lowest-index priority, one-cycle request, EOI handshake.
// Define INT_CTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer before edge detection (adds 2 cycles).
module int_controller #(
    parameter int         NSRC      = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic [7:0]      mem_addr,
    input  logic [7:0]      mem_w_data,
    input  logic            mem_w_en,
    output logic [7:0]      mem_r_data,
    output logic            int_req,
    output logic [7:0]      int_en,
    output logic [7:0]      int_vec
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

    state_t          state_reg;
    logic [7:0]      ctrl_reg;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] pend_reg;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] irq_prev_reg;
    logic [NSRC-1:0] irq_s;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] req_clr;
    logic [7:0]      vec_reg [NSRC];
    logic [2:0]      id_reg;
    logic [2:0]      win_id;
    logic [7:0]      win_vec;
    logic            int_req_reg;
    logic [7:0]      int_vec_reg;
    logic [7:0]      offset;
    logic            in_win;
    logic            wr_en;
    logic [7:0]      mask_ext;
    logic [7:0]      pend_ext;

`ifdef INT_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1_reg;
    logic [NSRC-1:0] sync2_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end
    assign irq_s = sync2_reg;
`else
    assign irq_s = irq_in;
`endif

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign offset   = mem_addr - BASE_ADDR;
    assign in_win   = (offset < 8'd12);
    assign wr_en    = mem_w_en && in_win;
    assign edges    = irq_s & ~irq_prev_reg;
    assign eligible = pend_reg & mask_reg;
    assign w1c      = (wr_en && offset == 8'd2) ? mem_w_data[NSRC-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_clr
            assign req_clr[gi] = (state_reg == REQ) && (id_reg == 3'(gi));
        end
    endgenerate

    // A new edge beats any clear landing on the same bit in the same cycle.
    assign pend_next = (pend_reg & ~w1c & ~req_clr) | edges;

    always_comb begin
        win_id  = '0;
        win_vec = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id  = 3'(i);
                win_vec = vec_reg[i];
            end
        end
    end

    always_comb begin
        mask_ext             = '0;
        mask_ext[NSRC-1:0]   = mask_reg;
        pend_ext             = '0;
        pend_ext[NSRC-1:0]   = pend_reg;
        mem_r_data           = '0;
        if (in_win) begin
            case (offset)
                8'd0:    mem_r_data = ctrl_reg;
                8'd1:    mem_r_data = mask_ext;
                8'd2:    mem_r_data = pend_ext;
                8'd3:    mem_r_data = {(state_reg == SERVICE), 4'b0000, id_reg};
                default: begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (offset == 8'(4 + i)) mem_r_data = vec_reg[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ctrl_reg     <= '0;
            mask_reg     <= '0;
            pend_reg     <= '0;
            irq_prev_reg <= '0;
            id_reg       <= '0;
            int_req_reg  <= 1'b0;
            int_vec_reg  <= '0;
            for (int i = 0; i < NSRC; i++) vec_reg[i] <= '0;
        end else begin
            irq_prev_reg <= irq_s;
            pend_reg     <= pend_next;
            if (wr_en && offset == 8'd0) ctrl_reg <= mem_w_data;
            if (wr_en && offset == 8'd1) mask_reg <= mem_w_data[NSRC-1:0];
            for (int i = 0; i < NSRC; i++) begin
                if (wr_en && offset == 8'(4 + i)) vec_reg[i] <= mem_w_data;
            end
            case (state_reg)
                IDLE: begin
                    int_req_reg <= 1'b0;
                    if (ctrl_reg[0] && (|eligible)) begin
                        id_reg      <= win_id;
                        int_vec_reg <= win_vec;
                        int_req_reg <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    int_req_reg <= 1'b0;
                    state_reg   <= SERVICE;
                end
                SERVICE: begin
                    int_req_reg <= 1'b0;
                    if (wr_en && offset == 8'd3) state_reg <= IDLE;
                end
                default: begin
                    int_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign int_req = int_req_reg;
    assign int_vec = int_vec_reg;
    assign int_en  = ctrl_reg;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: register table, request timing, priority, masking, W1C race, async reset.
module tb_int_controller;
    localparam int NSRC = 4;
`ifdef INT_CTRL_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif
    localparam int LAT = 2 + SYNC_D;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NSRC-1:0] irq_in = '0;
    logic [7:0]      mem_addr = '0;
    logic [7:0]      mem_w_data = '0;
    logic            mem_w_en = 1'b0;
    logic [7:0]      mem_r_data;
    logic            int_req;
    logic [7:0]      int_en;
    logic [7:0]      int_vec;

    int_controller #(.NSRC(NSRC), .BASE_ADDR(8'hF0)) dut (
        .clock(clock), .reset(reset), .irq_in(irq_in),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
        .mem_r_data(mem_r_data), .int_req(int_req), .int_en(int_en), .int_vec(int_vec)
    );

    always #5 clock = ~clock;

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t sb_q[$];
    int total = 0;
    int bad = 0;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; logic [7:0] exp; } tv_t;
    tv_t tbl[13];

    task automatic expect_val(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] act);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty actual=0x%0h", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.val);
            end else begin
                $display("ok   %s = 0x%0h", e.name, act);
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        mem_addr   = a;
        mem_w_data = d;
        mem_w_en   = 1'b1;
        @(negedge clock);
        mem_w_en   = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [7:0] a, input logic [7:0] e);
        expect_val(n, {24'd0, e});
        mem_addr = a;
        #1;
        observe({24'd0, mem_r_data});
    endtask

    task automatic quiet();
        @(negedge clock);
        irq_in = '0;
        repeat (SYNC_D + 2) @(negedge clock);
    endtask

    // Counts posedges after the current point; records first int_req cycle, high-cycle count and vector.
    task automatic watch(input int maxc, output int first, output int cnt, output logic [7:0] vec);
        first = -1;
        cnt   = 0;
        vec   = '0;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clock);
            #1;
            if (int_req === 1'b1) begin
                cnt++;
                if (first < 0) begin
                    first = c;
                    vec   = int_vec;
                end
            end
        end
    endtask

    task automatic req_chk(input string n, input int maxc, input int e_first, input int e_cnt, input logic [7:0] e_vec);
        int f, c;
        logic [7:0] v;
        expect_val({n, "_first"}, e_first);
        expect_val({n, "_cycles"}, e_cnt);
        if (e_cnt > 0) expect_val({n, "_vec"}, {24'd0, e_vec});
        watch(maxc, f, c, v);
        observe(f);
        observe(c);
        if (e_cnt > 0) observe({24'd0, v});
    endtask

    initial begin
        int seen;
        tbl[0]  = '{1'b1, 8'hF0, 8'hA4, 8'hA4};
        tbl[1]  = '{1'b1, 8'hF1, 8'hFF, 8'h0F};
        tbl[2]  = '{1'b1, 8'hF2, 8'hFF, 8'h00};
        tbl[3]  = '{1'b0, 8'hF3, 8'h00, 8'h00};
        tbl[4]  = '{1'b1, 8'hF4, 8'h11, 8'h11};
        tbl[5]  = '{1'b1, 8'hF5, 8'h21, 8'h21};
        tbl[6]  = '{1'b1, 8'hF6, 8'h40, 8'h40};
        tbl[7]  = '{1'b1, 8'hF7, 8'h63, 8'h63};
        tbl[8]  = '{1'b1, 8'hF8, 8'h99, 8'h00};
        tbl[9]  = '{1'b1, 8'hFB, 8'h77, 8'h00};
        tbl[10] = '{1'b1, 8'hFC, 8'h55, 8'h00};
        tbl[11] = '{1'b1, 8'hEF, 8'h55, 8'h00};
        tbl[12] = '{1'b0, 8'hF0, 8'h00, 8'hA4};

        repeat (2) @(negedge clock);
        reset = 1'b0;

        expect_val("rst_int_req", 0); observe({31'd0, int_req});
        expect_val("rst_int_vec", 0); observe({24'd0, int_vec});
        expect_val("rst_int_en", 0);  observe({24'd0, int_en});
        rd_chk("rst_stat", 8'hF3, 8'h00);
        rd_chk("rst_pend", 8'hF2, 8'h00);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
            else @(negedge clock);
            rd_chk($sformatf("reg_%0d_addr_%0h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
        end
        expect_val("int_en_out", 8'hA4); observe({24'd0, int_en});

        // Basic request.
        wr(8'hF0, 8'h01);
        quiet();
        irq_in = 4'b0100;
        req_chk("basic", 10, LAT, 1, 8'h40);
        rd_chk("basic_stat", 8'hF3, 8'h82);
        rd_chk("basic_pend", 8'hF2, 8'h00);
        wr(8'hF3, 8'h00);
        rd_chk("basic_stat_eoi", 8'hF3, 8'h02);

        // Priority and queuing; second request starts the cycle after EOI.
        quiet();
        irq_in = 4'b1010;
        req_chk("prio", 10, LAT, 1, 8'h21);
        rd_chk("prio_pend", 8'hF2, 8'h08);
        rd_chk("prio_stat", 8'hF3, 8'h81);
        wr(8'hF3, 8'h00);
        req_chk("queued", 4, 1, 1, 8'h63);
        wr(8'hF3, 8'h00);

        // Masking, then unmask.
        wr(8'hF1, 8'h00);
        quiet();
        irq_in = 4'b0001;
        req_chk("masked", 8, -1, 0, 8'h00);
        rd_chk("masked_pend", 8'hF2, 8'h01);
        wr(8'hF1, 8'h01);
        req_chk("unmask", 4, 1, 1, 8'h11);
        wr(8'hF3, 8'h00);

        // Global enable off.
        wr(8'hF0, 8'h00);
        wr(8'hF1, 8'h0F);
        quiet();
        irq_in = 4'b0100;
        req_chk("gdis", 8, -1, 0, 8'h00);
        rd_chk("gdis_pend", 8'hF2, 8'h04);

        // W1C on the same edge that detects a new irq_in[0] edge.
        quiet();
        irq_in[0] = 1'b1;
        repeat (SYNC_D) @(negedge clock);
        mem_addr   = 8'hF2;
        mem_w_data = 8'h01;
        mem_w_en   = 1'b1;
        @(negedge clock);
        mem_w_en   = 1'b0;
        rd_chk("race_pend", 8'hF2, 8'h05);
        wr(8'hF2, 8'h01);
        rd_chk("w1c_pend", 8'hF2, 8'h04);
        wr(8'hF0, 8'h01);
        req_chk("reenable", 4, 1, 1, 8'h40);
        wr(8'hF3, 8'h00);
        rd_chk("reenable_stat", 8'hF3, 8'h02);

        // Reset asserted during the int_req cycle.
        quiet();
        irq_in = 4'b1000;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(posedge clock);
            #1;
            if (int_req === 1'b1) seen = 1;
        end
        expect_val("midreq_seen", 1); observe(seen);
        reset = 1'b1;
        #1;
        expect_val("async_drop", 0); observe({31'd0, int_req});
        for (int a = 0; a < 4 + NSRC; a++) begin
            rd_chk($sformatf("post_rst_%0d", a), 8'(8'hF0 + a), 8'h00);
        end
        expect_val("post_rst_vec", 0); observe({24'd0, int_vec});
        expect_val("post_rst_en", 0);  observe({24'd0, int_en});
        irq_in = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
